// File: rtl/srl_win_readout_pkg.sv
// Shared encodings and helpers for the SRL window readout block.
package srl_win_readout_pkg;

  localparam int NSAMP_MAX_DEF = 16;

  typedef enum logic [1:0] {B_EMPTY, B_FILL, B_FULL, B_DRAIN} bank_st_e;
  typedef enum logic {C_IDLE, C_CAPT} cap_st_e;
  typedef enum logic {R_IDLE, R_RUN} rd_st_e;

  // Window length as stored with a bank: 0 means 1, anything above the bank depth saturates.
  function automatic logic [31:0] clamp_n(input logic [31:0] n, input logic [31:0] mx);
    if (n == 32'd0) return 32'd1;
    if (n > mx)     return mx;
    return n;
  endfunction

endpackage

// File: rtl/win_bank_2x.sv
// Two ping-pong window banks: one write port, one registered read port with hold.
module win_bank_2x #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic             wbank,
  input  logic [AW-1:0]    widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rbank,
  input  logic [AW-1:0]    ridx,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [2][DEPTH];

  always_ff @(posedge CLK)
    if (we) mem[wbank][widx] <= wdata;

  // Read register doubles as the output word; it only moves on re so it holds under backpressure.
  always_ff @(posedge CLK)
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[rbank][ridx];

endmodule

// File: rtl/srl_win_readout.sv
// Trigger-windowed capture of the SRL tap stream into ping-pong banks, drained as valid/ready words.
module srl_win_readout
  import srl_win_readout_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NSAMP_MAX = NSAMP_MAX_DEF,
  parameter int CW        = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] DIN,
  input  logic             TRIG,
  input  logic [CW-1:0]    NSAMP,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VLD,
  input  logic             DOUT_RDY,
  output logic             DOUT_LAST,
  output logic             BUSY,
  output logic             DUP,
  output logic             OVFL,
  output logic [7:0]       EVT_CNT
);

  localparam int AW = $clog2(NSAMP_MAX);

  bank_st_e      bst_q [2], bst_d [2];
  logic [CW-1:0] bn_q [2], bn_d [2];
  cap_st_e       cst_q, cst_d;
  rd_st_e        rst_q, rst_d;
  logic          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] k_q, k_d, ridx_q, ridx_d;
  logic          vld_q, vld_d, last_q, last_d;
  logic          dup_q, dup_d, ovfl_q, ovfl_d;
  logic [7:0]    evt_q, evt_d;
  logic [CW-1:0] nclamp, widx, rdidx;
  logic          we, re, rbank;

  assign nclamp = CW'(clamp_n(32'(NSAMP), 32'(NSAMP_MAX)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      bst_q[0] <= B_EMPTY; bst_q[1] <= B_EMPTY;
      bn_q[0]  <= '0;      bn_q[1]  <= '0;
      cst_q    <= C_IDLE;  rst_q    <= R_IDLE;
      wptr_q   <= 1'b0;    rptr_q   <= 1'b0;
      k_q      <= '0;      ridx_q   <= '0;
      vld_q    <= 1'b0;    last_q   <= 1'b0;
      dup_q    <= 1'b0;    ovfl_q   <= 1'b0;
      evt_q    <= '0;
    end else begin
      bst_q  <= bst_d;  bn_q   <= bn_d;
      cst_q  <= cst_d;  rst_q  <= rst_d;
      wptr_q <= wptr_d; rptr_q <= rptr_d;
      k_q    <= k_d;    ridx_q <= ridx_d;
      vld_q  <= vld_d;  last_q <= last_d;
      dup_q  <= dup_d;  ovfl_q <= ovfl_d;
      evt_q  <= evt_d;
    end
  end

  // Both FSMs share bank state; capture only touches EMPTY/FILL banks and readout only
  // FULL/DRAIN banks, so the two sections never update the same entry in one cycle.
  always_comb begin
    bst_d  = bst_q;  bn_d   = bn_q;
    cst_d  = cst_q;  rst_d  = rst_q;
    wptr_d = wptr_q; rptr_d = rptr_q;
    k_d    = k_q;    ridx_d = ridx_q;
    vld_d  = vld_q;  last_d = last_q;
    dup_d  = 1'b0;   ovfl_d = 1'b0;
    evt_d  = evt_q;
    we     = 1'b0;   widx   = '0;
    re     = 1'b0;   rbank  = rptr_q; rdidx = ridx_q;

    if (CE) begin
      unique case (cst_q)
        C_IDLE: if (TRIG) begin
          if (bst_q[wptr_q] == B_EMPTY) begin
            we = 1'b1;
            evt_d = evt_q + 8'd1;
            bn_d[wptr_q] = nclamp;
            if (nclamp == CW'(1)) begin
              bst_d[wptr_q] = B_FULL;
              wptr_d = ~wptr_q;
            end else begin
              bst_d[wptr_q] = B_FILL;
              k_d = CW'(1);
              cst_d = C_CAPT;
            end
          end else begin
            ovfl_d = 1'b1;
          end
        end
        C_CAPT: begin
          we = 1'b1;
          widx = k_q;
          dup_d = TRIG;
          if (k_q == bn_q[wptr_q] - CW'(1)) begin
            bst_d[wptr_q] = B_FULL;
            wptr_d = ~wptr_q;
            cst_d = C_IDLE;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      endcase
    end

    unique case (rst_q)
      R_IDLE: if (bst_q[rptr_q] == B_FULL) begin
        bst_d[rptr_q] = B_DRAIN;
        re = 1'b1; rdidx = '0;
        vld_d = 1'b1;
        last_d = (bn_q[rptr_q] == CW'(1));
        ridx_d = CW'(1);
        rst_d = R_RUN;
      end
      R_RUN: if (DOUT_RDY) begin
        if (last_q) begin
          bst_d[rptr_q] = B_EMPTY;
          rptr_d = ~rptr_q;
          if (bst_q[~rptr_q] == B_FULL) begin
            // Next window is already waiting: chain it without dropping VLD.
            bst_d[~rptr_q] = B_DRAIN;
            re = 1'b1; rbank = ~rptr_q; rdidx = '0;
            last_d = (bn_q[~rptr_q] == CW'(1));
            ridx_d = CW'(1);
          end else begin
            vld_d = 1'b0;
            last_d = 1'b0;
            rst_d = R_IDLE;
          end
        end else begin
          re = 1'b1;
          last_d = (ridx_q == bn_q[rptr_q] - CW'(1));
          ridx_d = ridx_q + CW'(1);
        end
      end
    endcase
  end

  win_bank_2x #(.WIDTH(WIDTH), .DEPTH(NSAMP_MAX), .AW(AW)) u_bank (
    .CLK   (CLK),
    .RST   (RST),
    .we    (we),
    .wbank (wptr_q),
    .widx  (widx[AW-1:0]),
    .wdata (DIN),
    .re    (re),
    .rbank (rbank),
    .ridx  (rdidx[AW-1:0]),
    .rdata (DOUT)
  );

  assign DOUT_VLD  = vld_q;
  assign DOUT_LAST = last_q;
  assign DUP       = dup_q;
  assign OVFL      = ovfl_q;
  assign EVT_CNT   = evt_q;
  assign BUSY      = (bst_q[0] != B_EMPTY) | (bst_q[1] != B_EMPTY) | (cst_q == C_CAPT);

endmodule

// File: tb/tb_srl_win_readout.sv
// Directed bench for srl_win_readout: hand-computed windows, pulses and counters.
module tb_srl_win_readout;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic [15:0] DIN = '0;
  logic        TRIG = 1'b0;
  logic [4:0]  NSAMP = '0;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        DOUT_RDY = 1'b1;
  logic        DOUT_LAST;
  logic        BUSY;
  logic        DUP;
  logic        OVFL;
  logic [7:0]  EVT_CNT;

  srl_win_readout dut (
    .CLK(CLK), .RST(RST), .CE(CE), .DIN(DIN), .TRIG(TRIG), .NSAMP(NSAMP),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .DOUT_RDY(DOUT_RDY), .DOUT_LAST(DOUT_LAST),
    .BUSY(BUSY), .DUP(DUP), .OVFL(OVFL), .EVT_CNT(EVT_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int mon_d [$];
  int mon_l [$];
  int mon_c [$];
  int dup_cnt = 0;
  int ovfl_cnt = 0;

  // Transfers are logged mid-cycle, when VLD/RDY/DOUT are settled for the coming edge.
  always @(negedge CLK) begin
    if (!RST) begin
      if (DOUT_VLD && DOUT_RDY) begin
        mon_d.push_back(int'(DOUT));
        mon_l.push_back(int'(DOUT_LAST));
        mon_c.push_back(cyc);
      end
      if (DUP)  dup_cnt  <= dup_cnt + 1;
      if (OVFL) ovfl_cnt <= ovfl_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_d [$];
  int exp_l [$];
  int cap_cyc [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    CE = 1'b0; TRIG = 1'b0; DIN = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    RST = 1'b1; CE = 1'b0; TRIG = 1'b0; DIN = '0;
    repeat (2) step();
    RST = 1'b0;
  endtask

  // DIN = base+k each cycle; CE every cycle or on even k only; TRIG on the listed k.
  task automatic run(input int base, input int n, input int t0, input int t1, input int t2,
                     input bit ce_alt);
    for (int k = 0; k < n; k++) begin
      DIN  = 16'(base + k);
      CE   = ce_alt ? (k % 2 == 0) : 1'b1;
      TRIG = (k == t0) || (k == t1) || (k == t2);
      step();
      cap_cyc[k] = cyc;
    end
    CE = 1'b0; TRIG = 1'b0; DIN = '0;
  endtask

  // Compares the words logged since mark with exp_d/exp_l; words must arrive on consecutive cycles.
  task automatic chk_win(input string tag, input int mark);
    int n;
    n = mon_d.size() - mark;
    chk({tag, " count"}, n, exp_d.size());
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      chk($sformatf("%s data[%0d]", tag, i), mon_d[mark+i], exp_d[i]);
      chk($sformatf("%s last[%0d]", tag, i), mon_l[mark+i], exp_l[i]);
      chk($sformatf("%s gap[%0d]", tag, i), mon_c[mark+i] - mon_c[mark], i);
    end
  endtask

  int mark, d0, o0;

  initial begin
    // reset state
    DOUT_RDY = 1'b1;
    do_reset();
    RST = 1'b1;
    step();
    chk("rst DOUT", DOUT, 0);
    chk("rst VLD", DOUT_VLD, 0);
    chk("rst LAST", DOUT_LAST, 0);
    chk("rst BUSY", BUSY, 0);
    chk("rst DUP", DUP, 0);
    chk("rst OVFL", OVFL, 0);
    chk("rst EVT", EVT_CNT, 0);
    RST = 1'b0;

    // 1: ramp, window of 4 from k=5, first VLD one cycle after the last capture edge
    mark = mon_d.size();
    NSAMP = 5'd4;
    run(0, 16, 5, -1, -1, 1'b0);
    idle(4);
    exp_d = '{5, 6, 7, 8}; exp_l = '{0, 0, 0, 1};
    chk_win("t1", mark);
    if (mon_c.size() > mark) chk("t1 latency", mon_c[mark] - cap_cyc[8], 1);
    else chk("t1 latency", 0, 1);
    chk("t1 EVT", EVT_CNT, 1);
    chk("t1 BUSY", BUSY, 0);

    // 2: CE every other cycle, only CE samples land in the window
    do_reset();
    mark = mon_d.size();
    NSAMP = 5'd3;
    run(100, 20, 4, -1, -1, 1'b1);
    idle(6);
    exp_d = '{104, 106, 108}; exp_l = '{0, 0, 1};
    chk_win("t2", mark);

    // 3: backpressure, both banks fill, third trigger overflows; then back-to-back drain
    do_reset();
    DOUT_RDY = 1'b0;
    NSAMP = 5'd2;
    o0 = ovfl_cnt;
    mark = mon_d.size();
    run(200, 60, 0, 20, 40, 1'b0);
    chk("t3 OVFL pulses", ovfl_cnt - o0, 1);
    chk("t3 hold VLD", DOUT_VLD, 1);
    chk("t3 hold DOUT", DOUT, 200);
    chk("t3 hold LAST", DOUT_LAST, 0);
    chk("t3 BUSY", BUSY, 1);
    chk("t3 EVT", EVT_CNT, 2);
    DOUT_RDY = 1'b1;
    idle(10);
    exp_d = '{200, 201, 220, 221}; exp_l = '{0, 1, 0, 1};
    chk_win("t3", mark);
    chk("t3 BUSY end", BUSY, 0);

    // 4: retrigger during capture is a DUP and does not split the window
    do_reset();
    NSAMP = 5'd6;
    d0 = dup_cnt;
    mark = mon_d.size();
    run(300, 16, 2, 4, -1, 1'b0);
    idle(6);
    chk("t4 DUP pulses", dup_cnt - d0, 1);
    exp_d = '{302, 303, 304, 305, 306, 307}; exp_l = '{0, 0, 0, 0, 0, 1};
    chk_win("t4", mark);
    chk("t4 EVT", EVT_CNT, 1);

    // 5a: NSAMP=0 behaves as a single word
    do_reset();
    NSAMP = 5'd0;
    mark = mon_d.size();
    run(400, 6, 1, -1, -1, 1'b0);
    idle(4);
    exp_d = '{401}; exp_l = '{1};
    chk_win("t5a", mark);

    // 5b: NSAMP=31 saturates at the bank depth
    do_reset();
    NSAMP = 5'd31;
    mark = mon_d.size();
    run(500, 24, 0, -1, -1, 1'b0);
    idle(20);
    exp_d = {}; exp_l = {};
    for (int i = 0; i < 16; i++) begin
      exp_d.push_back(500 + i);
      exp_l.push_back(i == 15);
    end
    chk_win("t5b", mark);

    // 6: reset mid-capture, reset mid-drain, then a clean capture
    do_reset();
    NSAMP = 5'd8;
    run(600, 4, 0, -1, -1, 1'b0);
    RST = 1'b1;
    step();
    chk("t6 capt VLD", DOUT_VLD, 0);
    chk("t6 capt BUSY", BUSY, 0);
    RST = 1'b0;
    mark = mon_d.size();
    idle(20);
    chk("t6 capt no words", mon_d.size() - mark, 0);

    NSAMP = 5'd8;
    run(600, 11, 0, -1, -1, 1'b0);
    chk("t6 drain active", DOUT_VLD, 1);
    RST = 1'b1;
    step();
    chk("t6 drain VLD", DOUT_VLD, 0);
    chk("t6 drain BUSY", BUSY, 0);
    chk("t6 drain EVT", EVT_CNT, 0);
    RST = 1'b0;
    mark = mon_d.size();
    idle(20);
    chk("t6 drain no words", mon_d.size() - mark, 0);

    NSAMP = 5'd2;
    mark = mon_d.size();
    run(700, 4, 0, -1, -1, 1'b0);
    idle(6);
    exp_d = '{700, 701}; exp_l = '{0, 1};
    chk_win("t6 clean", mark);
    chk("t6 EVT", EVT_CNT, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
